// File: rtl/hdu_sb.sv
// Hazard detection unit with a per-register load scoreboard, selectable branch
// flush policy and saturating stall/flush/freeze performance counters.
module hdu_sb #(
  parameter int RA_W     = 5,
  parameter int LOAD_LAT = 1,
  parameter int BR_MODE  = 0,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [RA_W-1:0]   ID_Rs,
  input  logic [RA_W-1:0]   ID_Rt,
  input  logic [RA_W-1:0]   EX_WR_out,
  input  logic              EX_MemtoReg,
  input  logic [1:0]        EX_JumpOP,
  input  logic              EX_Taken,
  input  logic              IC_stall,
  input  logic              DC_stall,
  output logic              PCWrite,
  output logic              IF_IDWrite,
  output logic              ID_EXWrite,
  output logic              EX_MWrite,
  output logic              M_WBWrite,
  output logic              IF_Flush,
  output logic              ID_Flush,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic [CNT_W-1:0]  cfrz_cnt
);

  localparam int         NREG     = 1 << RA_W;
  localparam logic [1:0] PEND_SET = 2'(LOAD_LAT - 1);

  typedef enum logic [1:0] {EV_NONE, EV_FREEZE, EV_FLUSH, EV_STALL} ev_t;

  logic [1:0] pend [NREG];
  logic       hz_ex;
  logic       hz_sb;
  logic       lu;
  logic       br;
  logic       freeze;
  logic       set_en;
  ev_t        ev;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Hazard, branch and freeze terms, resolved into a single prioritised event
  always_comb begin
    freeze = IC_stall || DC_stall;
    set_en = EX_MemtoReg && (EX_WR_out != '0);
    hz_ex  = set_en && ((EX_WR_out == ID_Rs) || (EX_WR_out == ID_Rt));
    hz_sb  = ((ID_Rs != '0) && (pend[ID_Rs] != 2'd0)) ||
             ((ID_Rt != '0) && (pend[ID_Rt] != 2'd0));
    lu     = hz_ex || hz_sb;
    if (BR_MODE == 1) begin
      br = (EX_JumpOP != 2'd0) && EX_Taken;
    end else begin
      br = (EX_JumpOP != 2'd0);
    end
    if (rst) begin
      ev = EV_NONE;
    end else if (freeze) begin
      ev = EV_FREEZE;
    end else if (br) begin
      ev = EV_FLUSH;
    end else if (lu) begin
      ev = EV_STALL;
    end else begin
      ev = EV_NONE;
    end
  end

  // Stage enables and flushes for the winning event
  always_comb begin
    PCWrite    = 1'b1;
    IF_IDWrite = 1'b1;
    ID_EXWrite = 1'b1;
    EX_MWrite  = 1'b1;
    M_WBWrite  = 1'b1;
    IF_Flush   = 1'b0;
    ID_Flush   = 1'b0;
    case (ev)
      EV_FREEZE: begin
        PCWrite    = 1'b0;
        IF_IDWrite = 1'b0;
        ID_EXWrite = 1'b0;
        EX_MWrite  = 1'b0;
        M_WBWrite  = 1'b0;
      end
      EV_FLUSH: begin
        IF_Flush = 1'b1;
        ID_Flush = 1'b1;
      end
      EV_STALL: begin
        PCWrite    = 1'b0;
        IF_IDWrite = 1'b0;
        ID_Flush   = 1'b1;
      end
      default: begin
        PCWrite = 1'b1;
      end
    endcase
  end

  // Scoreboard: a new load outranks the countdown of the same entry; freeze holds all
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        pend[i] <= 2'd0;
      end
    end else if (!freeze) begin
      for (int i = 0; i < NREG; i++) begin
        if (set_en && (EX_WR_out == RA_W'(i))) begin
          pend[i] <= PEND_SET;
        end else if (pend[i] != 2'd0) begin
          pend[i] <= pend[i] - 2'd1;
        end else begin
          pend[i] <= pend[i];
        end
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        pend[i] <= pend[i];
      end
    end
  end

  // Saturating performance counters, one per event class
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      cfrz_cnt  <= '0;
    end else begin
      case (ev)
        EV_FREEZE: cfrz_cnt  <= sat_inc(cfrz_cnt);
        EV_FLUSH:  flush_cnt <= sat_inc(flush_cnt);
        EV_STALL:  stall_cnt <= sat_inc(stall_cnt);
        default:   stall_cnt <= stall_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_hdu_sb.sv
// Directed bench for hdu_sb: three instances (LOAD_LAT=1/BR_MODE=0, LOAD_LAT=3/BR_MODE=1,
// LOAD_LAT=1/CNT_W=2) share one stimulus stream; expectations are hand-computed.
module tb_hdu_sb;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_wr;
  logic       ex_mtr, ex_tk, ic, dc;
  logic [1:0] ex_jop;

  // {PCWrite, IF_IDWrite, ID_EXWrite, EX_MWrite, M_WBWrite, IF_Flush, ID_Flush}
  wire [6:0]  ctl_a, ctl_b, ctl_c;
  wire [15:0] stall_a, flush_a, cfrz_a, stall_b, flush_b, cfrz_b;
  wire [1:0]  stall_c, flush_c, cfrz_c;

  localparam logic [6:0] DEF = 7'b11111_00;
  localparam logic [6:0] STL = 7'b00111_01;
  localparam logic [6:0] FLU = 7'b11111_11;
  localparam logic [6:0] FRZ = 7'b00000_00;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  hdu_sb #(.RA_W(5), .LOAD_LAT(1), .BR_MODE(0), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .ID_Rs(id_rs), .ID_Rt(id_rt), .EX_WR_out(ex_wr),
    .EX_MemtoReg(ex_mtr), .EX_JumpOP(ex_jop), .EX_Taken(ex_tk),
    .IC_stall(ic), .DC_stall(dc),
    .PCWrite(ctl_a[6]), .IF_IDWrite(ctl_a[5]), .ID_EXWrite(ctl_a[4]),
    .EX_MWrite(ctl_a[3]), .M_WBWrite(ctl_a[2]), .IF_Flush(ctl_a[1]), .ID_Flush(ctl_a[0]),
    .stall_cnt(stall_a), .flush_cnt(flush_a), .cfrz_cnt(cfrz_a));

  hdu_sb #(.RA_W(5), .LOAD_LAT(3), .BR_MODE(1), .CNT_W(16)) u_b (
    .clk(clk), .rst(rst), .ID_Rs(id_rs), .ID_Rt(id_rt), .EX_WR_out(ex_wr),
    .EX_MemtoReg(ex_mtr), .EX_JumpOP(ex_jop), .EX_Taken(ex_tk),
    .IC_stall(ic), .DC_stall(dc),
    .PCWrite(ctl_b[6]), .IF_IDWrite(ctl_b[5]), .ID_EXWrite(ctl_b[4]),
    .EX_MWrite(ctl_b[3]), .M_WBWrite(ctl_b[2]), .IF_Flush(ctl_b[1]), .ID_Flush(ctl_b[0]),
    .stall_cnt(stall_b), .flush_cnt(flush_b), .cfrz_cnt(cfrz_b));

  hdu_sb #(.RA_W(5), .LOAD_LAT(1), .BR_MODE(0), .CNT_W(2)) u_c (
    .clk(clk), .rst(rst), .ID_Rs(id_rs), .ID_Rt(id_rt), .EX_WR_out(ex_wr),
    .EX_MemtoReg(ex_mtr), .EX_JumpOP(ex_jop), .EX_Taken(ex_tk),
    .IC_stall(ic), .DC_stall(dc),
    .PCWrite(ctl_c[6]), .IF_IDWrite(ctl_c[5]), .ID_EXWrite(ctl_c[4]),
    .EX_MWrite(ctl_c[3]), .M_WBWrite(ctl_c[2]), .IF_Flush(ctl_c[1]), .ID_Flush(ctl_c[0]),
    .stall_cnt(stall_c), .flush_cnt(flush_c), .cfrz_cnt(cfrz_c));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] wr,
                     input logic mtr, input logic [1:0] jop, input logic tk,
                     input logic i_st, input logic d_st);
    id_rs = rs; id_rt = rt; ex_wr = wr; ex_mtr = mtr;
    ex_jop = jop; ex_tk = tk; ic = i_st; dc = d_st;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drv(5'd0, 5'd0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    mid(); chk("rst_ctl_a", 16'(ctl_a), 16'(DEF));
    tick(); tick();
    rst = 1'b0;
    chk("rst_stall_a", stall_a, 16'd0);
    chk("rst_flush_b", flush_b, 16'd0);
    chk("rst_cfrz_b", cfrz_b, 16'd0);

    // A: load r8 in EX, consumer in ID
    drv(5'd8, 5'd0, 5'd8, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    mid(); chk("A_ctl_a", 16'(ctl_a), 16'(STL)); chk("A_ctl_b", 16'(ctl_b), 16'(STL));
    tick(); chk("A_stall_a", stall_a, 16'd1);
    // B, C: load gone from EX; LOAD_LAT=3 keeps stalling from the scoreboard
    drv(5'd8, 5'd0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    mid(); chk("B_ctl_a", 16'(ctl_a), 16'(DEF)); chk("B_ctl_b", 16'(ctl_b), 16'(STL));
    tick();
    mid(); chk("C_ctl_b", 16'(ctl_b), 16'(STL));
    tick(); chk("C_stall_b", stall_b, 16'd3); chk("C_stall_a", stall_a, 16'd1);
    mid(); chk("D_ctl_b", 16'(ctl_b), 16'(DEF));
    tick();

    // E..H: load r9, consumer reaches ID two cycles later via rt
    drv(5'd1, 5'd2, 5'd9, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    mid(); chk("E_ctl_b", 16'(ctl_b), 16'(DEF));
    tick();
    drv(5'd3, 5'd0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    mid(); chk("F_ctl_b", 16'(ctl_b), 16'(DEF));
    tick();
    drv(5'd0, 5'd9, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    mid(); chk("G_ctl_b", 16'(ctl_b), 16'(STL)); chk("G_ctl_a", 16'(ctl_a), 16'(DEF));
    tick();
    mid(); chk("H_ctl_b", 16'(ctl_b), 16'(DEF));
    tick(); chk("H_stall_b", stall_b, 16'd4);

    // I..M: load r8, DC_stall held 4 cycles in the middle of the LOAD_LAT=3 penalty
    drv(5'd8, 5'd0, 5'd8, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    mid(); chk("I_ctl_b", 16'(ctl_b), 16'(STL));
    tick();
    drv(5'd8, 5'd0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    mid(); chk("J_ctl_b", 16'(ctl_b), 16'(STL));
    tick();
    drv(5'd8, 5'd0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      mid(); chk("K_ctl_b", 16'(ctl_b), 16'(FRZ));
      tick();
    end
    chk("K_cfrz_b", cfrz_b, 16'd4);
    chk("K_stall_b", stall_b, 16'd6);
    drv(5'd8, 5'd0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    mid(); chk("L_ctl_b", 16'(ctl_b), 16'(STL));
    tick();
    mid(); chk("M_ctl_b", 16'(ctl_b), 16'(DEF));
    tick(); chk("M_stall_b", stall_b, 16'd7);

    // N: IC_stall outranks a taken branch
    drv(5'd8, 5'd0, 5'd0, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0);
    mid(); chk("N_ctl_a", 16'(ctl_a), 16'(FRZ));
    tick(); chk("N_cfrz_a", cfrz_a, 16'd5); chk("N_flush_a", flush_a, 16'd0);

    // O, P: branch flush by mode
    drv(5'd0, 5'd0, 5'd0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0);
    mid(); chk("O_ctl_a", 16'(ctl_a), 16'(FLU)); chk("O_ctl_b", 16'(ctl_b), 16'(DEF));
    tick(); chk("O_flush_a", flush_a, 16'd1); chk("O_flush_b", flush_b, 16'd0);
    drv(5'd0, 5'd0, 5'd0, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0);
    mid(); chk("P_ctl_b", 16'(ctl_b), 16'(FLU));
    tick(); chk("P_flush_a", flush_a, 16'd2); chk("P_flush_b", flush_b, 16'd1);

    // Q..T: taken branch while pend[8]=1 hides the hazard
    drv(5'd8, 5'd0, 5'd8, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    tick();
    drv(5'd8, 5'd0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    tick(); chk("R_stall_b", stall_b, 16'd9);
    drv(5'd8, 5'd0, 5'd0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0);
    mid(); chk("S_ctl_b", 16'(ctl_b), 16'(FLU));
    tick(); chk("S_stall_b", stall_b, 16'd9); chk("S_flush_b", flush_b, 16'd2);
    drv(5'd8, 5'd0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    mid(); chk("T_ctl_b", 16'(ctl_b), 16'(DEF));
    tick();

    // U, V: load to r0 never creates a hazard
    drv(5'd0, 5'd0, 5'd0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    mid(); chk("U_ctl_a", 16'(ctl_a), 16'(DEF)); chk("U_ctl_b", 16'(ctl_b), 16'(DEF));
    tick();
    drv(5'd0, 5'd0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    mid(); chk("V_ctl_b", 16'(ctl_b), 16'(DEF));
    tick(); chk("V_stall_a", stall_a, 16'd3);

    // W..Y: reset while pend[8]=2
    drv(5'd8, 5'd0, 5'd8, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    drv(5'd8, 5'd0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    mid(); chk("X_ctl_b", 16'(ctl_b), 16'(DEF));
    tick();
    rst = 1'b0;
    chk("X_stall_b", stall_b, 16'd0); chk("X_flush_b", flush_b, 16'd0);
    chk("X_cfrz_b", cfrz_b, 16'd0); chk("X_stall_c", 16'(stall_c), 16'd0);
    mid(); chk("Y_ctl_b", 16'(ctl_b), 16'(DEF));
    tick(); chk("Y_stall_b", stall_b, 16'd0);

    // Saturation: five stall cycles on a 2-bit counter
    drv(5'd8, 5'd0, 5'd8, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      mid(); chk("sat_ctl_c", 16'(ctl_c), 16'(STL));
      tick();
      chk("sat_stall_c", 16'(stall_c), (k > 3) ? 16'd3 : 16'(k));
      chk("sat_stall_a", stall_a, 16'(k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
